// File: rtl/alu_rs_scheduler_pkg.sv
// Shared definitions for the ALU reservation station: opcode encodings,
// data/ROB-tag widths and the "no tag" / zero-word constants.
package alu_rs_scheduler_pkg;

    localparam int DATA_W    = 32;
    localparam int ROB_POS_W = 4;
    localparam int OPENUM_W  = 6;

    typedef logic [DATA_W-1:0]    DATA_TYPE;
    typedef logic [ROB_POS_W-1:0] ROB_POS_TYPE;

    typedef enum logic [OPENUM_W-1:0] {
        OPENUM_NOP   = 6'd0,
        OPENUM_ADD   = 6'd1,
        OPENUM_SUB,
        OPENUM_AND,
        OPENUM_OR,
        OPENUM_XOR,
        OPENUM_SLL,
        OPENUM_SRL,
        OPENUM_SRA,
        OPENUM_SLT,
        OPENUM_SLTU,
        OPENUM_BEQ,
        OPENUM_BNE,
        OPENUM_BLT,
        OPENUM_BGE,
        OPENUM_BLTU,
        OPENUM_BGEU,
        OPENUM_LUI,
        OPENUM_AUIPC,
        OPENUM_JAL,
        OPENUM_JALR
    } openum_e;

    // Tag 0 means "operand value already present".
    localparam ROB_POS_TYPE ZERO_ROB  = '0;
    localparam DATA_TYPE    ZERO_WORD = '0;

endpackage

// File: rtl/alu_rs_scheduler_rs_prio_enc.sv
// Lowest-index priority encoder with a found flag; used for both the
// free-slot search and the ready-slot select.
module rs_prio_enc #(
    parameter int N = 16,
    parameter int W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0] req,
    output logic [W-1:0] idx,
    output logic         found
);

    // Scan high to low so the lowest set bit is the last (winning) assignment.
    always_comb begin
        idx   = '0;
        found = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                idx   = W'(i);
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/alu_rs_scheduler.sv
// Reservation station for the shared ALU: holds dispatched instructions,
// snoops both result buses for missing operands and issues one ready entry per cycle.
module alu_rs_scheduler
    import alu_rs_scheduler_pkg::*;
#(
    parameter int ENTRIES = 16,
    parameter int TAG_W   = 4,
    parameter int OP_W    = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rdy,
    input  logic             clear,
    input  logic             in_valid,
    input  logic [OP_W-1:0]  in_op,
    input  logic [TAG_W-1:0] in_qj,
    input  logic [TAG_W-1:0] in_qk,
    input  logic [31:0]      in_vj,
    input  logic [31:0]      in_vk,
    input  logic [31:0]      in_imm,
    input  logic [31:0]      in_pc,
    input  logic [TAG_W-1:0] in_rob_tag,
    output logic             full,
    input  logic [TAG_W-1:0] alu_cdb_tag,
    input  logic [31:0]      alu_cdb_value,
    input  logic [TAG_W-1:0] lsb_cdb_tag,
    input  logic [31:0]      lsb_cdb_value,
    output logic [OP_W-1:0]  out_op,
    output logic [31:0]      out_value1,
    output logic [31:0]      out_value2,
    output logic [31:0]      out_imm,
    output logic [31:0]      out_pc,
    output logic [TAG_W-1:0] out_rob_tag
);

    localparam int               IDX_W  = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;
    localparam logic [TAG_W-1:0] NO_TAG = TAG_W'(ZERO_ROB);
    localparam logic [OP_W-1:0]  NOP_OP = OP_W'(OPENUM_NOP);

    logic [ENTRIES-1:0] busy_reg;
    logic [OP_W-1:0]    op_reg  [ENTRIES];
    DATA_TYPE           vj_reg  [ENTRIES];
    DATA_TYPE           vk_reg  [ENTRIES];
    DATA_TYPE           imm_reg [ENTRIES];
    DATA_TYPE           pc_reg  [ENTRIES];
    logic [TAG_W-1:0]   qj_reg  [ENTRIES];
    logic [TAG_W-1:0]   qk_reg  [ENTRIES];
    logic [TAG_W-1:0]   tag_reg [ENTRIES];

    logic [ENTRIES-1:0] free_vec;
    logic [ENTRIES-1:0] ready_vec;
    logic [IDX_W-1:0]   free_idx;
    logic [IDX_W-1:0]   sel_idx;
    logic               free_found;
    logic               sel_found;
    logic               advance;
    logic               do_dispatch;
    logic               do_issue;

    for (genvar gi = 0; gi < ENTRIES; gi++) begin : g_vec
        assign free_vec[gi]  = !busy_reg[gi];
        assign ready_vec[gi] = busy_reg[gi] && (qj_reg[gi] == NO_TAG) && (qk_reg[gi] == NO_TAG);
    end

    rs_prio_enc #(.N(ENTRIES), .W(IDX_W)) u_free_enc (
        .req   (free_vec),
        .idx   (free_idx),
        .found (free_found)
    );

    rs_prio_enc #(.N(ENTRIES), .W(IDX_W)) u_sel_enc (
        .req   (ready_vec),
        .idx   (sel_idx),
        .found (sel_found)
    );

    assign full        = !free_found;
    assign advance     = rdy && !clear;
    assign do_dispatch = advance && in_valid && free_found;
    assign do_issue    = advance && sel_found;

    // Returns {tag, value} after snooping both buses; ALU wins on a shared tag.
    function automatic logic [TAG_W+DATA_W-1:0] snoop(input logic [TAG_W-1:0] q,
                                                      input DATA_TYPE         v);
        if (q != NO_TAG && q == alu_cdb_tag)      return {NO_TAG, alu_cdb_value};
        else if (q != NO_TAG && q == lsb_cdb_tag) return {NO_TAG, lsb_cdb_value};
        else                                      return {q, v};
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_reg <= '0;
        end else if (rdy) begin
            if (clear) begin
                busy_reg <= '0;
            end else begin
                for (int i = 0; i < ENTRIES; i++) begin
                    if (do_dispatch && free_idx == IDX_W'(i))
                        busy_reg[i] <= 1'b1;
                    else if (do_issue && sel_idx == IDX_W'(i))
                        busy_reg[i] <= 1'b0;
                end
            end
        end
    end

    // Payload needs no reset: an entry is only looked at while busy.
    always_ff @(posedge clk) begin
        if (advance) begin
            for (int i = 0; i < ENTRIES; i++) begin
                if (do_dispatch && free_idx == IDX_W'(i)) begin
                    op_reg[i]               <= in_op;
                    imm_reg[i]              <= in_imm;
                    pc_reg[i]               <= in_pc;
                    tag_reg[i]              <= in_rob_tag;
                    {qj_reg[i], vj_reg[i]}  <= snoop(in_qj, in_vj);
                    {qk_reg[i], vk_reg[i]}  <= snoop(in_qk, in_vk);
                end else if (busy_reg[i]) begin
                    {qj_reg[i], vj_reg[i]}  <= snoop(qj_reg[i], vj_reg[i]);
                    {qk_reg[i], vk_reg[i]}  <= snoop(qk_reg[i], vk_reg[i]);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_op      <= NOP_OP;
            out_value1  <= ZERO_WORD;
            out_value2  <= ZERO_WORD;
            out_imm     <= ZERO_WORD;
            out_pc      <= ZERO_WORD;
            out_rob_tag <= NO_TAG;
        end else if (rdy) begin
            if (clear) begin
                out_op      <= NOP_OP;
                out_value1  <= ZERO_WORD;
                out_value2  <= ZERO_WORD;
                out_imm     <= ZERO_WORD;
                out_pc      <= ZERO_WORD;
                out_rob_tag <= NO_TAG;
            end else if (sel_found) begin
                out_op      <= op_reg[sel_idx];
                out_value1  <= vj_reg[sel_idx];
                out_value2  <= vk_reg[sel_idx];
                out_imm     <= imm_reg[sel_idx];
                out_pc      <= pc_reg[sel_idx];
                out_rob_tag <= tag_reg[sel_idx];
            end else begin
                out_op      <= NOP_OP;
                out_rob_tag <= NO_TAG;
            end
        end
    end

endmodule

// File: tb/tb_alu_rs_scheduler.sv
// Scoreboard bench: a slot-array reference model predicts each issue, a
// negedge monitor compares whatever the scheduler presents to the ALU.
module tb_alu_rs_scheduler;
    import alu_rs_scheduler_pkg::*;

    localparam int N = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rdy = 1'b1;
    logic        clear = 1'b0;
    logic        in_valid = 1'b0;
    logic [5:0]  in_op = '0;
    logic [3:0]  in_qj = '0, in_qk = '0, in_rob_tag = '0;
    logic [31:0] in_vj = '0, in_vk = '0, in_imm = '0, in_pc = '0;
    logic [3:0]  alu_cdb_tag = '0, lsb_cdb_tag = '0;
    logic [31:0] alu_cdb_value = '0, lsb_cdb_value = '0;
    logic        full;
    logic [5:0]  out_op;
    logic [31:0] out_value1, out_value2, out_imm, out_pc;
    logic [3:0]  out_rob_tag;

    alu_rs_scheduler #(.ENTRIES(N), .TAG_W(4), .OP_W(6)) dut (
        .clk(clk), .rst(rst), .rdy(rdy), .clear(clear),
        .in_valid(in_valid), .in_op(in_op), .in_qj(in_qj), .in_qk(in_qk),
        .in_vj(in_vj), .in_vk(in_vk), .in_imm(in_imm), .in_pc(in_pc),
        .in_rob_tag(in_rob_tag), .full(full),
        .alu_cdb_tag(alu_cdb_tag), .alu_cdb_value(alu_cdb_value),
        .lsb_cdb_tag(lsb_cdb_tag), .lsb_cdb_value(lsb_cdb_value),
        .out_op(out_op), .out_value1(out_value1), .out_value2(out_value2),
        .out_imm(out_imm), .out_pc(out_pc), .out_rob_tag(out_rob_tag)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [5:0]  op;
        logic [31:0] v1, v2, imm, pc;
        logic [3:0]  tag;
    } issue_t;

    typedef struct {
        bit          busy;
        logic [5:0]  op;
        logic [31:0] vj, vk, imm, pc;
        logic [3:0]  qj, qk, tag;
    } slot_t;

    slot_t  m   [N];
    slot_t  pre [N];
    issue_t exp_q[$];
    issue_t held;
    bit     held_valid = 1'b0;
    int     iss, fr;
    int     checks = 0;
    int     errors = 0;

    function automatic bit model_full();
        for (int i = 0; i < N; i++)
            if (!m[i].busy) return 1'b0;
        return 1'b1;
    endfunction

    // Operand capture rule: a nonzero waiting tag matching a bus takes its value, ALU first.
    function automatic logic [35:0] capture(input logic [3:0] q, input logic [31:0] v);
        if (q != 4'd0 && q == alu_cdb_tag) return {4'd0, alu_cdb_value};
        if (q != 4'd0 && q == lsb_cdb_tag) return {4'd0, lsb_cdb_value};
        return {q, v};
    endfunction

    // Reference model: one step per rising edge, using the station as it was before the edge.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N; i++) m[i].busy = 1'b0;
            held_valid = 1'b0;
            exp_q.delete();
        end else if (!rdy) begin
            if (held_valid) exp_q.push_back(held);
        end else if (clear) begin
            for (int i = 0; i < N; i++) m[i].busy = 1'b0;
            held_valid = 1'b0;
        end else begin
            pre = m;
            iss = -1;
            fr  = -1;
            for (int i = 0; i < N; i++) begin
                if (iss < 0 && pre[i].busy && pre[i].qj == 0 && pre[i].qk == 0) iss = i;
                if (fr < 0 && !pre[i].busy) fr = i;
            end
            if (iss >= 0) begin
                held.op  = pre[iss].op;  held.v1 = pre[iss].vj; held.v2 = pre[iss].vk;
                held.imm = pre[iss].imm; held.pc = pre[iss].pc; held.tag = pre[iss].tag;
                held_valid = 1'b1;
                exp_q.push_back(held);
                m[iss].busy = 1'b0;
            end else begin
                held_valid = 1'b0;
            end
            for (int i = 0; i < N; i++) begin
                if (pre[i].busy && i != iss) begin
                    {m[i].qj, m[i].vj} = capture(pre[i].qj, pre[i].vj);
                    {m[i].qk, m[i].vk} = capture(pre[i].qk, pre[i].vk);
                end
            end
            if (in_valid && fr >= 0) begin
                m[fr].busy = 1'b1;
                m[fr].op   = in_op;  m[fr].imm = in_imm; m[fr].pc = in_pc; m[fr].tag = in_rob_tag;
                {m[fr].qj, m[fr].vj} = capture(in_qj, in_vj);
                {m[fr].qk, m[fr].vk} = capture(in_qk, in_vk);
            end
        end
    end

    // Monitor: compares away from the rising edge.
    always @(negedge clk) begin
        issue_t e;
        checks++;
        if (full !== model_full()) begin
            errors++;
            $display("FAIL full: got %0b want %0b", full, model_full());
        end
        checks++;
        if (out_op != 6'(OPENUM_NOP)) begin
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_issue: got op=%0d tag=%0d want none", out_op, out_rob_tag);
            end else begin
                e = exp_q.pop_front();
                if (out_op !== e.op || out_value1 !== e.v1 || out_value2 !== e.v2 ||
                    out_imm !== e.imm || out_pc !== e.pc || out_rob_tag !== e.tag) begin
                    errors++;
                    $display("FAIL issue: got op=%0d v1=%h v2=%h imm=%h pc=%h tag=%0d want op=%0d v1=%h v2=%h imm=%h pc=%h tag=%0d",
                             out_op, out_value1, out_value2, out_imm, out_pc, out_rob_tag,
                             e.op, e.v1, e.v2, e.imm, e.pc, e.tag);
                end else begin
                    $display("issue op=%0d tag=%0d v1=%h v2=%h", out_op, out_rob_tag, out_value1, out_value2);
                end
            end
        end else if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            errors++;
            $display("FAIL missing_issue: got op=NOP want op=%0d tag=%0d", e.op, e.tag);
        end else if (out_rob_tag !== 4'd0) begin
            errors++;
            $display("FAIL nop_tag: got %0d want 0", out_rob_tag);
        end
    end

    task automatic cycle();
        @(negedge clk);
        #1;
        in_valid    = 1'b0;
        clear       = 1'b0;
        alu_cdb_tag = 4'd0;
        lsb_cdb_tag = 4'd0;
    endtask

    task automatic dispatch(input openum_e op, input logic [3:0] qj, input logic [3:0] qk,
                            input logic [31:0] vj, input logic [31:0] vk, input logic [3:0] tag);
        in_valid   = 1'b1;
        in_op      = 6'(op);
        in_qj      = qj;
        in_qk      = qk;
        in_vj      = vj;
        in_vk      = vk;
        in_rob_tag = tag;
        in_imm     = $urandom;
        in_pc      = $urandom;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (2) cycle();
        rst = 1'b0;
        cycle();

        // Independent ADD with both operands present.
        dispatch(OPENUM_ADD, 4'd0, 4'd0, 32'd5, 32'd7, 4'd3);
        repeat (3) cycle();

        // SUB waiting on LSB tag 2.
        dispatch(OPENUM_SUB, 4'd2, 4'd0, 32'd0, 32'd1, 4'd4);
        repeat (2) cycle();
        lsb_cdb_tag = 4'd2; lsb_cdb_value = 32'd10;
        repeat (3) cycle();

        // Same-cycle bypass from the ALU bus.
        dispatch(OPENUM_ADD, 4'd6, 4'd0, 32'd0, 32'd9, 4'd5);
        alu_cdb_tag = 4'd6; alu_cdb_value = 32'hFFFF_FFFF;
        repeat (3) cycle();

        // Fill every slot waiting on tag 9, attempt one extra, then wake all.
        for (int i = 0; i < N; i++) begin
            dispatch(OPENUM_XOR, 4'd9, 4'd0, 32'd0, $urandom, 4'(i));
            cycle();
        end
        dispatch(OPENUM_OR, 4'd0, 4'd0, 32'd1, 32'd2, 4'd15);
        cycle();
        alu_cdb_tag = 4'd9; alu_cdb_value = 32'h1234_5678;
        repeat (N + 3) cycle();

        // Clear against a same-cycle dispatch and a ready entry.
        dispatch(OPENUM_AND, 4'd0, 4'd0, 32'd3, 32'd4, 4'd7);
        cycle();
        dispatch(OPENUM_SLT, 4'd0, 4'd0, 32'd1, 32'd1, 4'd8);
        clear = 1'b1;
        repeat (3) cycle();

        // Reset mid-run with three busy entries and a dispatch during reset.
        for (int i = 0; i < 3; i++) begin
            dispatch(OPENUM_SLL, 4'd11, 4'd12, 32'd0, 32'd0, 4'(i + 1));
            cycle();
        end
        rst = 1'b1;
        dispatch(OPENUM_ADD, 4'd0, 4'd0, 32'd1, 32'd1, 4'd2);
        cycle();
        rst = 1'b0;
        repeat (2) cycle();

        // Outputs hold while rdy is low.
        dispatch(OPENUM_SRA, 4'd0, 4'd0, 32'hF000_0000, 32'd4, 4'd6);
        repeat (2) cycle();
        rdy = 1'b0;
        repeat (2) cycle();
        rdy = 1'b1;
        cycle();

        // Randomized traffic.
        for (int c = 0; c < 700; c++) begin
            rdy = ($urandom_range(0, 9) != 0);
            if (rdy) begin
                if (!model_full() && $urandom_range(0, 2) != 0)
                    dispatch(openum_e'(6'($urandom_range(1, 20))),
                             ($urandom_range(0, 1) != 0) ? 4'($urandom_range(1, 15)) : 4'd0,
                             ($urandom_range(0, 1) != 0) ? 4'($urandom_range(1, 15)) : 4'd0,
                             $urandom, $urandom, 4'($urandom_range(0, 15)));
                alu_cdb_tag   = 4'($urandom_range(0, 15));
                lsb_cdb_tag   = ($urandom_range(0, 5) == 0) ? alu_cdb_tag : 4'($urandom_range(0, 15));
                alu_cdb_value = $urandom;
                lsb_cdb_value = $urandom;
                clear         = ($urandom_range(0, 99) == 0);
            end
            cycle();
        end
        rdy = 1'b1;
        repeat (3) cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
